// File: rtl/iencoder.sv
// RV32I field-to-instruction encoder with a 2-entry skid buffer on the output stream.
// Illegal field combinations produce out_illegal=1 with a zero instruction word.
module iencoder #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           inst_type,
    input  logic [4:0]           funct,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [31:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic                 out_illegal,
    output logic [CNT_WIDTH-1:0] enc_count,
    output logic [CNT_WIDTH-1:0] ill_count
);
    localparam logic [3:0] T_LUI     = 4'd1;
    localparam logic [3:0] T_AUIPC   = 4'd2;
    localparam logic [3:0] T_JAL     = 4'd3;
    localparam logic [3:0] T_JALR    = 4'd4;
    localparam logic [3:0] T_BRANCH  = 4'd5;
    localparam logic [3:0] T_LOAD    = 4'd6;
    localparam logic [3:0] T_STORE   = 4'd7;
    localparam logic [3:0] T_INT_IMM = 4'd8;
    localparam logic [3:0] T_INT_REG = 4'd9;
    localparam logic [3:0] T_FENCE   = 4'd10;

    localparam logic [4:0] F_ADD = 5'd0,  F_SUB = 5'd1,  F_SLT = 5'd2,  F_SLTU = 5'd3;
    localparam logic [4:0] F_XOR = 5'd4,  F_OR  = 5'd5,  F_AND = 5'd6,  F_SLL  = 5'd7;
    localparam logic [4:0] F_SRL = 5'd8,  F_SRA = 5'd9,  F_EQ  = 5'd10, F_NEQ  = 5'd11;
    localparam logic [4:0] F_LT  = 5'd12, F_GTE = 5'd13, F_LTU = 5'd14, F_GTEU = 5'd15;
    localparam logic [4:0] F_BYTE = 5'd16, F_HWORD = 5'd17, F_WORD = 5'd18;
    localparam logic [4:0] F_BYTEU = 5'd19, F_HWORDU = 5'd20;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    // ---------------- field decode helpers ----------------
    logic [2:0]  w_alu_f3, w_br_f3, w_mem_f3;
    logic        w_alu_ok, w_alu_shift, w_alu_alt, w_br_ok, w_mem_ok;
    logic [31:0] w_sra11, w_sra12, w_sra20;
    logic        w_fit12, w_fit13, w_fit21, w_shamt_ok, w_u_ok;

    // Range checks: the value fits in N signed bits iff bits [31:N-1] all equal the sign.
    assign w_sra11    = $signed(imm) >>> 11;
    assign w_sra12    = $signed(imm) >>> 12;
    assign w_sra20    = $signed(imm) >>> 20;
    assign w_fit12    = (&w_sra11) | ~(|w_sra11);
    assign w_fit13    = (&w_sra12) | ~(|w_sra12);
    assign w_fit21    = (&w_sra20) | ~(|w_sra20);
    assign w_shamt_ok = (imm[31:5] == 27'd0);
    assign w_u_ok     = (imm[11:0] == 12'd0);
    assign w_alu_alt  = (funct == F_SUB) || (funct == F_SRA);

    always_comb begin
        w_alu_ok    = 1'b1;
        w_alu_shift = 1'b0;
        w_alu_f3    = 3'd0;
        case (funct)
            F_ADD, F_SUB: w_alu_f3 = 3'd0;
            F_SLL:        begin w_alu_f3 = 3'd1; w_alu_shift = 1'b1; end
            F_SLT:        w_alu_f3 = 3'd2;
            F_SLTU:       w_alu_f3 = 3'd3;
            F_XOR:        w_alu_f3 = 3'd4;
            F_SRL, F_SRA: begin w_alu_f3 = 3'd5; w_alu_shift = 1'b1; end
            F_OR:         w_alu_f3 = 3'd6;
            F_AND:        w_alu_f3 = 3'd7;
            default:      w_alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_br_ok = 1'b1;
        w_br_f3 = 3'd0;
        case (funct)
            F_EQ:    w_br_f3 = 3'd0;
            F_NEQ:   w_br_f3 = 3'd1;
            F_LT:    w_br_f3 = 3'd4;
            F_GTE:   w_br_f3 = 3'd5;
            F_LTU:   w_br_f3 = 3'd6;
            F_GTEU:  w_br_f3 = 3'd7;
            default: w_br_ok = 1'b0;
        endcase
    end

    // Unsigned widths share funct3 bit 2; stores reject them via that bit.
    always_comb begin
        w_mem_ok = 1'b1;
        w_mem_f3 = 3'd0;
        case (funct)
            F_BYTE:   w_mem_f3 = 3'd0;
            F_HWORD:  w_mem_f3 = 3'd1;
            F_WORD:   w_mem_f3 = 3'd2;
            F_BYTEU:  w_mem_f3 = 3'd4;
            F_HWORDU: w_mem_f3 = 3'd5;
            default:  w_mem_ok = 1'b0;
        endcase
    end

    // ---------------- instruction assembly ----------------
    logic        w_ill;
    logic [31:0] w_word;
    logic [32:0] w_result;

    always_comb begin
        w_ill  = 1'b0;
        w_word = 32'd0;
        case (inst_type)
            T_LUI: begin
                w_ill  = !w_u_ok;
                w_word = {imm[31:12], rd, 7'b0110111};
            end
            T_AUIPC: begin
                w_ill  = !w_u_ok;
                w_word = {imm[31:12], rd, 7'b0010111};
            end
            T_JAL: begin
                w_ill  = !w_fit21 || imm[0];
                w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            end
            T_JALR: begin
                w_ill  = !w_fit12;
                w_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            end
            T_BRANCH: begin
                w_ill  = !w_br_ok || !w_fit13 || imm[0];
                w_word = {imm[12], imm[10:5], rs2, rs1, w_br_f3, imm[4:1], imm[11], 7'b1100011};
            end
            T_LOAD: begin
                w_ill  = !w_mem_ok || !w_fit12;
                w_word = {imm[11:0], rs1, w_mem_f3, rd, 7'b0000011};
            end
            T_STORE: begin
                w_ill  = !w_mem_ok || w_mem_f3[2] || !w_fit12;
                w_word = {imm[11:5], rs2, rs1, w_mem_f3, imm[4:0], 7'b0100011};
            end
            T_INT_IMM: begin
                if (w_alu_shift) begin
                    w_ill  = !w_shamt_ok;
                    w_word = {(w_alu_alt ? 7'b0100000 : 7'b0000000), imm[4:0], rs1, w_alu_f3, rd, 7'b0010011};
                end else begin
                    w_ill  = !w_alu_ok || (funct == F_SUB) || !w_fit12;
                    w_word = {imm[11:0], rs1, w_alu_f3, rd, 7'b0010011};
                end
            end
            T_INT_REG: begin
                w_ill  = !w_alu_ok;
                w_word = {(w_alu_alt ? 7'b0100000 : 7'b0000000), rs2, rs1, w_alu_f3, rd, 7'b0110011};
            end
            T_FENCE: w_word = 32'h0FF0000F;
            default: w_ill = 1'b1;
        endcase
        w_result = {w_ill, (w_ill ? 32'd0 : w_word)};
    end

    // ---------------- skid buffer ----------------
    logic [1:0]           r_state, w_state_next;
    logic                 r_in_ready;
    logic [32:0]          r_head, r_skid;
    logic [CNT_WIDTH-1:0] r_enc_count, r_ill_count;
    logic                 w_push, w_pop;

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != S_EMPTY);
    assign out_inst    = r_head[31:0];
    assign out_illegal = r_head[32];
    assign enc_count   = r_enc_count;
    assign ill_count   = r_ill_count;
    assign w_push      = in_valid && r_in_ready;
    assign w_pop       = out_valid && out_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_push) w_state_next = S_ONE;
            S_ONE: begin
                if (w_push && !w_pop)      w_state_next = S_TWO;
                else if (!w_push && w_pop) w_state_next = S_EMPTY;
            end
            S_TWO:   if (w_pop) w_state_next = S_ONE;
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b0;
            r_head      <= 33'd0;
            r_skid      <= 33'd0;
            r_enc_count <= '0;
            r_ill_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != S_TWO);
            case (r_state)
                S_EMPTY: if (w_push) r_head <= w_result;
                S_ONE: begin
                    if (w_push && w_pop) r_head <= w_result;
                    else if (w_push)     r_skid <= w_result;
                    else if (w_pop)      r_head <= 33'd0;
                end
                S_TWO:   if (w_pop) r_head <= r_skid;
                default: r_head <= 33'd0;
            endcase
            if (w_pop) begin
                if (r_head[32]) r_ill_count <= r_ill_count + CNT_WIDTH'(1);
                else            r_enc_count <= r_enc_count + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_iencoder.sv
// Bench for iencoder: scoreboard of expected words built from the RV32I format rules,
// directed literal cases, backpressure/reset scenarios and a long randomized stream.
module tb_iencoder;
    localparam int T_LUI = 1, T_AUIPC = 2, T_JAL = 3, T_JALR = 4, T_BRANCH = 5;
    localparam int T_LOAD = 6, T_STORE = 7, T_INT_IMM = 8, T_INT_REG = 9, T_FENCE = 10;
    localparam int F_ADD = 0, F_SUB = 1, F_SLT = 2, F_SLTU = 3, F_XOR = 4, F_OR = 5, F_AND = 6;
    localparam int F_SLL = 7, F_SRL = 8, F_SRA = 9, F_EQ = 10, F_NEQ = 11, F_LT = 12, F_GTE = 13;
    localparam int F_LTU = 14, F_GTEU = 15, F_BYTE = 16, F_HWORD = 17, F_WORD = 18;
    localparam int F_BYTEU = 19, F_HWORDU = 20;
    localparam int FM_NONE = 0, FM_I = 1, FM_S = 2, FM_B = 3, FM_U = 4, FM_J = 5, FM_SH = 6;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, out_illegal;
    logic [3:0]  inst_type = '0;
    logic [4:0]  funct = '0, rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0, out_inst;
    logic [15:0] enc_count, ill_count;

    iencoder #(.CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst_type(inst_type), .funct(funct), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_illegal(out_illegal), .enc_count(enc_count), .ill_count(ill_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    bit chk_en = 1'b0;
    logic [15:0] m_enc = '0, m_ill = '0;

    typedef struct {
        logic [32:0] exp;
        logic [31:0] imm;
        int          fm;
    } ent_t;
    ent_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int alu_f3(int f);
        case (f)
            F_ADD, F_SUB: return 0;
            F_SLL:        return 1;
            F_SLT:        return 2;
            F_SLTU:       return 3;
            F_XOR:        return 4;
            F_SRL, F_SRA: return 5;
            F_OR:         return 6;
            F_AND:        return 7;
            default:      return -1;
        endcase
    endfunction

    function automatic int br_f3(int f);
        case (f)
            F_EQ: return 0;  F_NEQ: return 1; F_LT: return 4;
            F_GTE: return 5; F_LTU: return 6; F_GTEU: return 7;
            default: return -1;
        endcase
    endfunction

    function automatic int mem_f3(int f, bit is_load);
        case (f)
            F_BYTE:   return 0;
            F_HWORD:  return 1;
            F_WORD:   return 2;
            F_BYTEU:  return is_load ? 4 : -1;
            F_HWORDU: return is_load ? 5 : -1;
            default:  return -1;
        endcase
    endfunction

    function automatic int fmt_of(int t, int f);
        case (t)
            T_LUI, T_AUIPC:        return FM_U;
            T_JAL:                 return FM_J;
            T_JALR, T_LOAD:        return FM_I;
            T_BRANCH:              return FM_B;
            T_STORE:               return FM_S;
            T_INT_IMM:             return (f == F_SLL || f == F_SRL || f == F_SRA) ? FM_SH : FM_I;
            default:               return FM_NONE;
        endcase
    endfunction

    function automatic logic [32:0] model(int t, int f, int d, int s1, int s2, logic [31:0] im);
        longint      s = longint'($signed(im));
        int          fm = fmt_of(t, f);
        int          f3 = 0, f7 = 0, op = 0;
        bit          ill = 1'b0;
        logic [31:0] w;
        case (t)
            T_LUI:     op = 'h37;
            T_AUIPC:   op = 'h17;
            T_JAL:     op = 'h6F;
            T_JALR:    op = 'h67;
            T_BRANCH:  begin op = 'h63; f3 = br_f3(f); end
            T_LOAD:    begin op = 'h03; f3 = mem_f3(f, 1'b1); end
            T_STORE:   begin op = 'h23; f3 = mem_f3(f, 1'b0); end
            T_INT_IMM: begin op = 'h13; f3 = alu_f3(f); ill = (f == F_SUB); f7 = (f == F_SRA) ? 32 : 0; end
            T_INT_REG: begin op = 'h33; f3 = alu_f3(f); f7 = (f == F_SUB || f == F_SRA) ? 32 : 0; end
            T_FENCE:   return {1'b0, 32'h0FF0000F};
            default:   ill = 1'b1;
        endcase
        if (f3 < 0) ill = 1'b1;
        case (fm)
            FM_I, FM_S: if (s < -2048 || s > 2047) ill = 1'b1;
            FM_SH:      if (s < 0 || s > 31) ill = 1'b1;
            FM_B:       if (s < -4096 || s > 4094 || im[0]) ill = 1'b1;
            FM_J:       if (s < -(64'sd1 << 20) || s > (64'sd1 << 20) - 2 || im[0]) ill = 1'b1;
            FM_U:       if ((im & 32'hFFF) != 0) ill = 1'b1;
            default:    ;
        endcase
        w = 32'(op) | (32'(f3 & 7) << 12);
        case (fm)
            FM_NONE: w |= (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(d) << 7);
            FM_I:    w |= ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(d) << 7);
            FM_SH:   w |= (32'(f7) << 25) | ((im & 32'h1F) << 20) | (32'(s1) << 15) | (32'(d) << 7);
            FM_S:    w |= (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | ((im & 32'h1F) << 7);
            FM_B:    w |= (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
                        | (32'(s1) << 15) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7);
            FM_U:    w |= (im & 32'hFFFFF000) | (32'(d) << 7);
            default: w |= (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 1) << 20)
                        | (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7);
        endcase
        return ill ? {1'b1, 32'h0} : {1'b0, w};
    endfunction

    // Decoder-side view: recover the immediate from an encoded word.
    function automatic logic [31:0] dec_imm(int fm, logic [31:0] w);
        case (fm)
            FM_I:    return {{20{w[31]}}, w[31:20]};
            FM_S:    return {{20{w[31]}}, w[31:25], w[11:7]};
            FM_B:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            FM_U:    return {w[31:12], 12'b0};
            FM_J:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            FM_SH:   return {27'b0, w[24:20]};
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- per-cycle scoreboard ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("enc_count", 64'(enc_count), 64'(m_enc));
            chk("ill_count", 64'(ill_count), 64'(m_ill));
            if (out_valid && q.size() != 0) begin
                chk("out_word", 64'({out_illegal, out_inst}), 64'(q[0].exp));
                if (!q[0].exp[32] && q[0].fm != FM_NONE)
                    chk("imm_roundtrip", 64'(dec_imm(q[0].fm, out_inst)), 64'(q[0].imm));
                if (out_ready) begin
                    if (q[0].exp[32]) m_ill++;
                    else              m_enc++;
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                ent_t e;
                e.exp = model(int'(inst_type), int'(funct), int'(rd), int'(rs1), int'(rs2), imm);
                e.imm = imm;
                e.fm  = fmt_of(int'(inst_type), int'(funct));
                q.push_back(e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        chk_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_word", 64'({out_illegal, out_inst}), 64'(0));
        chk("rst_counts", 64'({enc_count, ill_count}), 64'(0));
        q.delete(); m_enc = '0; m_ill = '0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_in_ready", 64'(in_ready), 64'(1));
        chk_en = 1'b1;
    endtask

    task automatic set_fields(input int t, input int f, input int d, input int s1, input int s2, input logic [31:0] im);
        inst_type = 4'(t); funct = 5'(f); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = im;
    endtask

    task automatic send1(input string nm, input int t, input int f, input int d, input int s1, input int s2,
                         input logic [31:0] im, input logic [32:0] lit);
        chk({"model_", nm}, 64'(model(t, f, d, s1, s2, im)), 64'(lit));
        out_ready = 1'b1;
        set_fields(t, f, d, s1, s2, im);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({"dut_", nm}, 64'({out_valid, out_illegal, out_inst}), 64'({1'b1, lit}));
        @(posedge clk); #1;
    endtask

    task automatic rand_fields();
        int t, f, fm, r;
        longint lo, hi, v;
        t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 10));
        case (t)
            T_INT_IMM, T_INT_REG: f = int'($urandom_range(0, 9));
            T_BRANCH:             f = int'($urandom_range(10, 15));
            T_LOAD:               f = int'($urandom_range(16, 20));
            T_STORE:              f = int'($urandom_range(16, 18));
            default:              f = int'($urandom_range(0, 31));
        endcase
        if ($urandom_range(0, 19) == 0) f = int'($urandom_range(0, 31));
        fm = fmt_of(t, f);
        lo = -2048; hi = 2047;
        if (fm == FM_SH) begin lo = 0; hi = 31; end
        if (fm == FM_B)  begin lo = -4096; hi = 4094; end
        if (fm == FM_J)  begin lo = -(64'sd1 << 20); hi = (64'sd1 << 20) - 2; end
        r = int'($urandom_range(0, 9));
        if (fm == FM_U) begin
            imm = (r == 0) ? $urandom : ($urandom & 32'hFFFFF000);
        end else if (fm == FM_NONE || r == 0) begin
            imm = $urandom;
        end else if (r == 1) begin
            case ($urandom_range(0, 3))
                0: v = lo;
                1: v = hi;
                2: v = lo - 1;
                default: v = hi + 1;
            endcase
            imm = 32'(v);
        end else begin
            v = lo + longint'($urandom_range(0, 32'(hi - lo)));
            if (fm == FM_B || fm == FM_J) v = v - (v & 1) + ((r == 2) ? 1 : 0);
            imm = 32'(v);
        end
        set_fields(t, f, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        do_reset();

        send1("addi", T_INT_IMM, F_ADD, 1, 0, 0, 32'd5, {1'b0, 32'h00500093});
        chk("enc_after_addi", 64'(enc_count), 64'(1));
        send1("sub", T_INT_REG, F_SUB, 3, 1, 2, 32'd0, {1'b0, 32'h402081B3});
        send1("srai", T_INT_IMM, F_SRA, 5, 6, 0, 32'd3, {1'b0, 32'h40335293});
        send1("beq", T_BRANCH, F_EQ, 0, 1, 2, 32'd8, {1'b0, 32'h00208463});
        send1("sw", T_STORE, F_WORD, 0, 1, 2, 32'd4, {1'b0, 32'h0020A223});
        send1("lui", T_LUI, 0, 1, 0, 0, 32'h12345000, {1'b0, 32'h123450B7});
        send1("fence", T_FENCE, 0, 7, 3, 4, 32'h12345678, {1'b0, 32'h0FF0000F});

        do_reset();
        send1("ill_b_odd", T_BRANCH, F_EQ, 0, 1, 2, 32'd7, {1'b1, 32'h0});
        send1("ill_i_range", T_INT_IMM, F_ADD, 1, 1, 0, 32'd4096, {1'b1, 32'h0});
        send1("ill_st_byteu", T_STORE, F_BYTEU, 0, 1, 2, 32'd0, {1'b1, 32'h0});
        chk("ill_count_3", 64'({enc_count, ill_count}), 64'({16'd0, 16'd3}));

        // Backpressure: two words fill the skid, the third waits until space frees.
        out_ready = 1'b0;
        set_fields(T_INT_IMM, F_ADD, 1, 0, 0, 32'd1); in_valid = 1'b1;
        @(posedge clk); #1;
        set_fields(T_INT_IMM, F_ADD, 1, 0, 0, 32'd2);
        @(posedge clk); #1;
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        set_fields(T_INT_IMM, F_ADD, 1, 0, 0, 32'd3);
        repeat (2) @(posedge clk); #1;
        chk("bp_hold_head", 64'({out_valid, out_inst}), 64'({1'b1, 32'h00100093}));
        out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_all_delivered", 64'({out_valid, enc_count}), 64'({1'b0, 16'd3}));

        // Reset with two words buffered: nothing may come out afterwards.
        out_ready = 1'b0;
        set_fields(T_INT_IMM, F_ADD, 2, 0, 0, 32'd9); in_valid = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk_en = 1'b0; in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_state", 64'({out_valid, in_ready, enc_count, ill_count}), 64'(0));
        rst = 1'b0; q.delete(); m_enc = '0; m_ill = '0;
        @(posedge clk); #1;
        chk_en = 1'b1; out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("midrst_no_stale", 64'({out_valid, enc_count}), 64'(0));

        // Randomized stream with random backpressure.
        for (int i = 0; i < 20000; i++) begin
            rand_fields();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("drain_empty", 64'(q.size()), 64'(0));
        chk("drain_total", 64'(enc_count + ill_count), 64'(16'(m_enc + m_ill)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
